// File: rtl/vec_demux1_3.sv
// rtl/vec_demux1_3.sv - registered 1-to-3 vector demultiplexer with per-channel holding registers
module vec_demux1_3 #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [M-1:0][N-1:0]   in_data,
  output logic                  out_valid_a,
  output logic                  out_valid_b,
  output logic                  out_valid_c,
  input  logic                  out_ready_a,
  input  logic                  out_ready_b,
  input  logic                  out_ready_c,
  output logic [M-1:0][N-1:0]   out_data_a,
  output logic [M-1:0][N-1:0]   out_data_b,
  output logic [M-1:0][N-1:0]   out_data_c,
  input  logic                  err_clr,
  output logic                  err,
  output logic [7:0]            drop_cnt
);

  localparam logic [1:0] SEL_BAD = 2'b11;

  logic [2:0]                 valid_q, valid_d;
  logic [M-1:0][N-1:0]        data_q [3];
  logic [M-1:0][N-1:0]        data_d [3];
  logic                       err_q, err_d;
  logic [7:0]                 drop_cnt_q, drop_cnt_d;
  logic [2:0]                 out_ready;
  logic                       accept;
  logic                       drop;

  assign out_ready = {out_ready_c, out_ready_b, out_ready_a};

  // Ready toward the producer: invalid selects are always swallowed, otherwise the target slot must be free or draining
  always_comb begin
    in_ready = 1'b1;
    if (in_sel != SEL_BAD) begin
      in_ready = !valid_q[in_sel] || out_ready[in_sel];
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && (in_sel == SEL_BAD);

  // Next state of each channel slot; a simultaneous drain and accept keeps the slot full with the new word
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 3; k++) begin
      data_d[k] = data_q[k];
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
      if (accept && (in_sel == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
  end

  // Sticky error and saturating drop counter; a drop at the same edge as err_clr keeps err set
  always_comb begin
    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (drop) begin
      err_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // State registers, cleared asynchronously so a held word is discarded immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      for (int k = 0; k < 3; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      for (int k = 0; k < 3; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid_a = valid_q[0];
  assign out_valid_b = valid_q[1];
  assign out_valid_c = valid_q[2];
  assign out_data_a  = data_q[0];
  assign out_data_b  = data_q[1];
  assign out_data_c  = data_q[2];
  assign err         = err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_vec_demux1_3.sv
// tb/tb_vec_demux1_3.sv - directed scoreboard bench for vec_demux1_3
module tb_vec_demux1_3;

  localparam int N = 16;
  localparam int M = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_sel;
  logic [M-1:0][N-1:0] in_data;
  logic                out_valid_a, out_valid_b, out_valid_c;
  logic                out_ready_a, out_ready_b, out_ready_c;
  logic [M-1:0][N-1:0] out_data_a, out_data_b, out_data_c;
  logic                err_clr;
  logic                err;
  logic [7:0]          drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop_b  = 0;

  logic [255:0] q_a [$];
  logic [255:0] q_b [$];
  logic [255:0] q_c [$];

  always #5 clk = ~clk;

  vec_demux1_3 #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid_a(out_valid_a), .out_valid_b(out_valid_b), .out_valid_c(out_valid_c),
    .out_ready_a(out_ready_a), .out_ready_b(out_ready_b), .out_ready_c(out_ready_c),
    .out_data_a(out_data_a), .out_data_b(out_data_b), .out_data_c(out_data_c),
    .err_clr(err_clr), .err(err), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int k, input logic [255:0] d);
    logic [255:0] e;
    e = '0;
    case (k)
      0: begin
        check("sb_a_nonempty", 256'(q_a.size() > 0), 256'(1));
        if (q_a.size() > 0) e = q_a.pop_front();
        check("sb_a_data", d, e);
      end
      1: begin
        check("sb_b_nonempty", 256'(q_b.size() > 0), 256'(1));
        if (q_b.size() > 0) e = q_b.pop_front();
        check("sb_b_data", d, e);
        n_pop_b++;
      end
      default: begin
        check("sb_c_nonempty", 256'(q_c.size() > 0), 256'(1));
        if (q_c.size() > 0) e = q_c.pop_front();
        check("sb_c_data", d, e);
      end
    endcase
  endtask

  // Record the transfers that will happen at the next edge, then advance past it
  task automatic cycle();
    #1;
    if (in_valid && in_ready) begin
      case (in_sel)
        2'd0: q_a.push_back(in_data);
        2'd1: q_b.push_back(in_data);
        2'd2: q_c.push_back(in_data);
        default: ;
      endcase
    end
    if (out_valid_a && out_ready_a) pop_check(0, out_data_a);
    if (out_valid_b && out_ready_b) pop_check(1, out_data_b);
    if (out_valid_c && out_ready_c) pop_check(2, out_data_c);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pat(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(0));
    check({tag, "_data_a"}, out_data_a, '0);
    check({tag, "_data_b"}, out_data_b, '0);
    check({tag, "_data_c"}, out_data_c, '0);
    check({tag, "_err"}, 256'(err), 256'(0));
    check({tag, "_drop_cnt"}, 256'(drop_cnt), 256'(0));
  endtask

  initial begin
    logic [255:0] a_word;

    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0;
    out_ready_a = 1'b0; out_ready_b = 1'b0; out_ready_c = 1'b0; err_clr = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_in_ready", 256'(in_ready), 256'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill A, B, C on consecutive edges with consumers stalled
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = pat(16'h0001); cycle();
    check("fill1_valid", 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(3'b100));
    check("fill1_data_a", out_data_a, pat(16'h0001));
    in_sel = 2'd1; in_data = pat(16'h0002); cycle();
    check("fill2_valid", 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(3'b110));
    check("fill2_data_b", out_data_b, pat(16'h0002));
    in_sel = 2'd2; in_data = pat(16'h0003); cycle();
    check("fill3_valid", 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(3'b111));
    check("fill3_data_c", out_data_c, pat(16'h0003));
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("full_in_ready_sel%0d", s), 256'(in_ready), 256'(s == 3));
    end
    out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
    cycle();
    check("drain_all_valid", 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(0));
    out_ready_a = 1'b0; out_ready_c = 1'b0;

    // Stream 8 words to B with its consumer always ready
    in_valid = 1'b1; in_sel = 2'd1;
    for (int i = 0; i < 8; i++) begin
      in_data = pat(16'h0B00 + 16'(i)) ^ 256'($urandom);
      #1;
      check($sformatf("stream_in_ready_%0d", i), 256'(in_ready), 256'(1));
      cycle();
      check($sformatf("stream_valid_b_%0d", i), 256'(out_valid_b), 256'(1));
    end
    in_valid = 1'b0;
    cycle();
    check("stream_done_valid_b", 256'(out_valid_b), 256'(0));
    check("stream_pop_count", 256'(n_pop_b), 256'(9));
    out_ready_b = 1'b0;

    // Stall A for 5 cycles while C still accepts
    in_valid = 1'b1; in_sel = 2'd0; in_data = pat(16'hA5A5); a_word = pat(16'hA5A5);
    cycle();
    in_sel = 2'd2; in_data = pat(16'hC3C3);
    #1;
    check("stall_c_in_ready", 256'(in_ready), 256'(1));
    cycle();
    check("stall_c_valid", 256'(out_valid_c), 256'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      in_sel = 2'd0; in_data = pat(16'hDEAD);
      cycle();
      check($sformatf("stall_a_valid_%0d", i), 256'(out_valid_a), 256'(1));
      check($sformatf("stall_a_data_%0d", i), out_data_a, a_word);
    end
    in_valid = 1'b0;
    out_ready_a = 1'b1; out_ready_c = 1'b1;
    cycle();
    check("stall_a_drained", 256'(out_valid_a), 256'(0));
    check("stall_c_drained", 256'(out_valid_c), 256'(0));
    check("stall_a_data_kept", out_data_a, a_word);
    out_ready_a = 1'b0; out_ready_c = 1'b0;

    // Invalid-select drops
    in_valid = 1'b1; in_sel = 2'd3; in_data = pat(16'hBAD0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("drop_valid_%0d", i), 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(0));
    end
    check("drop3_err", 256'(err), 256'(1));
    check("drop3_cnt", 256'(drop_cnt), 256'(3));
    err_clr = 1'b1;
    cycle();
    check("drop_clr_race_err", 256'(err), 256'(1));
    check("drop_clr_race_cnt", 256'(drop_cnt), 256'(4));
    in_valid = 1'b0;
    cycle();
    check("clr_err", 256'(err), 256'(0));
    check("clr_cnt_kept", 256'(drop_cnt), 256'(4));
    err_clr = 1'b0;
    in_valid = 1'b1;
    repeat (260) cycle();
    check("drop_saturate", 256'(drop_cnt), 256'(8'hFF));
    check("drop_sat_err", 256'(err), 256'(1));
    check("drop_data_a_kept", out_data_a, a_word);
    in_valid = 1'b0;

    // Asynchronous reset with A and C full
    in_valid = 1'b1; in_sel = 2'd0; in_data = pat(16'h1111); cycle();
    in_sel = 2'd2; in_data = pat(16'h3333); cycle();
    in_valid = 1'b0;
    check("pre_rst_valid", 256'({out_valid_a, out_valid_b, out_valid_c}), 256'(3'b101));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    q_a.delete(); q_b.delete(); q_c.delete();
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; in_data = pat(16'h7777);
    #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    cycle();
    in_valid = 1'b0;
    check("post_rst_valid_a", 256'(out_valid_a), 256'(1));
    check("post_rst_data_a", out_data_a, pat(16'h7777));
    out_ready_a = 1'b1;
    cycle();
    check("post_rst_drained", 256'(out_valid_a), 256'(0));
    check("sb_empty", 256'(q_a.size() + q_b.size() + q_c.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
